// File: rtl/mbc_control_sequencer.sv
// rtl/mbc_control_sequencer.sv - T-state sequencer issuing fetch/indirect/execute control strobes
// Optional feature macro: SEQ_ONEHOT_CHECK_EN (traps non-one-hot decodes at the end of T2).

module mbc_control_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] decoded_signal,
    input  logic       ir_i,
    input  logic       dr_zero,
    output logic       running,
    output logic [6:0] t_state,
    output logic       ar_ld_pc,
    output logic       ar_ld_ir,
    output logic       ar_ld_mem,
    output logic       ar_inc,
    output logic       pc_inc,
    output logic       pc_ld_ar,
    output logic       ir_ld,
    output logic       dr_ld,
    output logic       dr_inc,
    output logic       mem_rd,
    output logic       mem_wr_ac,
    output logic       mem_wr_pc,
    output logic       mem_wr_dr,
    output logic       ac_and,
    output logic       ac_add,
    output logic       ac_ld_dr,
    output logic       illegal_op
);

    typedef enum logic [2:0] {
        T0 = 3'd0,
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4,
        T5 = 3'd5,
        T6 = 3'd6
    } tstate_e;

    tstate_e    sc;
    logic [7:0] d;
    logic       advance;

`ifndef SEQ_ONEHOT_CHECK_EN
    // Priority-resolve a malformed decode: lowest set bit wins, nothing set means halt.
    function automatic logic [7:0] lowest_set(input logic [7:0] v);
        logic [7:0] r;
        r = 8'h80;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) begin
                r    = '0;
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction
`endif

    // Decide whether the current T-state continues the instruction; every other case wraps to T0.
    always_comb begin
        advance = 1'b0;
        case (sc)
            T0, T1, T2: advance = 1'b1;
            T3:         advance = !d[7];
            T4:         advance = d[0] | d[1] | d[2] | d[5] | d[6];
            T5:         advance = d[6];
            default:    advance = 1'b0;
        endcase
    end

`ifdef SEQ_ONEHOT_CHECK_EN
    logic illegal_q;
    assign illegal_op = illegal_q;

    // Sequence counter, run flag, decode latch and sticky illegal-decode trap.
    always_ff @(posedge clk) begin
        if (rst) begin
            running   <= 1'b0;
            sc        <= T0;
            d         <= '0;
            illegal_q <= 1'b0;
        end else if (!running) begin
            if (start) begin
                running <= 1'b1;
                sc      <= T0;
            end
        end else if (sc == T2) begin
            d <= decoded_signal;
            if (!$onehot(decoded_signal)) begin
                illegal_q <= 1'b1;
                running   <= 1'b0;
                sc        <= T0;
            end else begin
                sc <= T3;
            end
        end else if (advance) begin
            sc <= tstate_e'(sc + 3'd1);
        end else begin
            sc <= T0;
            if (sc == T3) begin
                running <= 1'b0;
            end
        end
    end
`else
    assign illegal_op = 1'b0;

    // Sequence counter, run flag and priority-resolved decode latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            running <= 1'b0;
            sc      <= T0;
            d       <= '0;
        end else if (!running) begin
            if (start) begin
                running <= 1'b1;
                sc      <= T0;
            end
        end else if (sc == T2) begin
            d  <= lowest_set(decoded_signal);
            sc <= T3;
        end else if (advance) begin
            sc <= tstate_e'(sc + 3'd1);
        end else begin
            sc <= T0;
            if (sc == T3) begin
                running <= 1'b0;
            end
        end
    end
`endif

    // One-hot T-state view, forced to zero while idle so every strobe is gated by running.
    always_comb begin
        t_state = '0;
        if (running) begin
            t_state = 7'b000_0001 << sc;
        end
    end

    // Control strobes decoded from the T-state, the latched decode and live ir_i/dr_zero.
    always_comb begin
        ar_ld_pc  = t_state[0];
        ir_ld     = t_state[1];
        ar_ld_ir  = t_state[2];
        ar_ld_mem = t_state[3] & !d[7] & ir_i;
        mem_rd    = t_state[1]
                  | (t_state[3] & !d[7] & ir_i)
                  | (t_state[4] & (d[0] | d[1] | d[2] | d[6]));
        dr_ld     = t_state[4] & (d[0] | d[1] | d[2] | d[6]);
        mem_wr_ac = t_state[4] & d[3];
        pc_ld_ar  = (t_state[4] & d[4]) | (t_state[5] & d[5]);
        mem_wr_pc = t_state[4] & d[5];
        ar_inc    = t_state[4] & d[5];
        ac_and    = t_state[5] & d[0];
        ac_add    = t_state[5] & d[1];
        ac_ld_dr  = t_state[5] & d[2];
        dr_inc    = t_state[5] & d[6];
        mem_wr_dr = t_state[6] & d[6];
        pc_inc    = t_state[1] | (t_state[6] & d[6] & dr_zero);
    end

endmodule
